// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential 2*DW / DW restoring divider.
// DIV_TRUNC_EN selects the approximate variant that skips the low quotient bits.
package div_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned TRUNC_DEF = 2;

`ifdef DIV_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of CALC iterations for one division.
    function automatic int unsigned step_count(input int unsigned dw, input int unsigned trunc);
        return TRUNC_EN ? (dw - trunc) : dw;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder against the divisor.
module div_step #(
    parameter int unsigned DW = 8
) (
    input  logic [DW:0]   t,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] rem_next_c,
    output logic          qbit_c
);

    logic [DW:0] b_ext;

    always_comb begin
        b_ext      = {1'b0, b};
        rem_next_c = DW'(t);
        qbit_c     = 1'b0;
        // Partial remainder stays below b, so the difference always fits DW bits.
        if (t >= b_ext) begin
            rem_next_c = DW'(t - b_ext);
            qbit_c     = 1'b1;
        end
    end

endmodule

// File: rtl/div16_8_seq.sv
// Iterative restoring divider O[2DW-1:0] / B[DW-1:0] -> Q, R, one quotient bit per cycle.
// Build macro DIV_TRUNC_EN: run DW-TRUNC steps, zero Q low bits and R.
module div16_8_seq
    import div_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TRUNC = TRUNC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] O,
    input  logic [DW-1:0]   B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   Q,
    output logic [DW-1:0]   R,
    output logic            dz,
    output logic            ovf
);

    localparam int unsigned STEPS = step_count(DW, TRUNC);
    localparam int unsigned CW    = $clog2(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [DW:0]   t_c;
    logic [DW-1:0] rem_next_c;
    logic          qbit_c;
    logic [DW-1:0] quo_shift_c;

    assign t_c         = {rem_q, dvd_q[DW-1]};
    assign quo_shift_c = {quo_q[DW-2:0], qbit_c};

    div_step #(.DW(DW)) u_step (
        .t          (t_c),
        .b          (b_q),
        .rem_next_c (rem_next_c),
        .qbit_c     (qbit_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        b_d         = b_q;
        quo_d       = quo_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d        = B;
                    dvd_d      = O[DW-1:0];
                    rem_d      = O[2*DW-1:DW];
                    quo_d      = '0;
                    cnt_d      = CW'(STEPS - 1);
                    dz_d       = 1'b0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                    // Divide-by-zero takes priority over overflow; both finish immediately.
                    if (B == '0) begin
                        dz_d        = 1'b1;
                        quo_d       = '1;
                        rem_d       = O[DW-1:0];
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else if (O[2*DW-1:DW] >= B) begin
                        ovf_d       = 1'b1;
                        quo_d       = '1;
                        rem_d       = '0;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next_c;
                quo_d = quo_shift_c;
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`ifdef DIV_TRUNC_EN
                    quo_d = quo_shift_c << TRUNC;
                    rem_d = '0;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            b_q         <= '0;
            quo_q       <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            b_q         <= b_d;
            quo_q       <= quo_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = quo_q;
    assign R         = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div16_8_seq.sv
// Directed, table-driven bench for div16_8_seq plus stall and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_div16_8_seq;

    typedef struct {
        logic [15:0] o;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] O;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        dz;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    div16_8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .O         (O),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact expectations are hand-computed; the truncated build rescales normal results.
    function automatic vec_t adjust(input vec_t v);
        vec_t a = v;
`ifdef DIV_TRUNC_EN
        if (!v.dz && !v.ovf) begin
            a.q   = 8'((16'(v.o >> 2) / 16'(v.b)) << 2);
            a.r   = 8'h00;
            a.lat = 7;
        end
`endif
        return a;
    endfunction

    // Launch one operation and wait for its result; out_ready is left to the caller.
    task automatic run_op(input string name, input vec_t v);
        vec_t e;
        int   lat;
        e = adjust(v);
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        O        = v.o;
        B        = v.b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        O        = 16'($urandom);
        B        = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(e.lat));
        chk({name, "_Q"},       32'(Q),   32'(e.q));
        chk({name, "_R"},       32'(R),   32'(e.r));
        chk({name, "_dz"},      32'(dz),  32'(e.dz));
        chk({name, "_ovf"},     32'(ovf), 32'(e.ovf));
    endtask

    task automatic retire(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_retire_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_retire_ready"}, 32'(in_ready),  32'd1);
    endtask

    vec_t vecs[12];
    vec_t sv;
    vec_t se;

    initial begin
        //          O         B      Q      R      dz    ovf   lat
        vecs[0]  = '{16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, 9};
        vecs[1]  = '{16'h3039, 8'h00, 8'hFF, 8'h39, 1'b1, 1'b0, 1};
        vecs[2]  = '{16'hFF00, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[3]  = '{16'h0EFF, 8'h0F, 8'hFF, 8'h0E, 1'b0, 1'b0, 9};
        vecs[4]  = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9};
        vecs[5]  = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9};
        vecs[6]  = '{16'h00FF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 9};
        vecs[7]  = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9};
        vecs[8]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[9]  = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
        vecs[10] = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[11] = '{16'h00C8, 8'h0A, 8'h14, 8'h00, 1'b0, 1'b0, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        O         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q",         32'(Q),         32'd0);
        chk("rst_R",         32'(R),         32'd0);
        chk("rst_dz",        32'(dz),        32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DIV_TRUNC_EN
        sv = '{16'h03E8, 8'h07, 8'h8C, 8'h00, 1'b0, 1'b0, 7};
        run_op("trunc_hand", sv);
        retire("trunc_hand");
`endif

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
            retire($sformatf("vec%0d", i));
        end

        // Consumer stalls: result must hold and a second request must be dropped.
        se = adjust(vecs[0]);
        run_op("stall", vecs[0]);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            O        = 16'h1111;
            B        = 8'h02;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_ready", c), 32'(in_ready),  32'd0);
            chk($sformatf("stall%0d_Q", c),     32'(Q),         32'(se.q));
            chk($sformatf("stall%0d_R", c),     32'(R),         32'(se.r));
            chk($sformatf("stall%0d_flags", c), 32'({dz, ovf}), 32'd0);
        end
        in_valid = 1'b0;
        retire("stall");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no_queue%0d", c), 32'(out_valid), 32'd0);
        end

        // Reset four cycles into CALC discards the partial result.
        @(negedge clk);
        in_valid = 1'b1;
        O        = 16'h3039;
        B        = 8'h7B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready),  32'd1);
        chk("midrst_Q",     32'(Q),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sv = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9};
        run_op("after_rst", sv);
        retire("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
